maple_phy_mux: RTL and testbench

Parametrised Maple Bus line interface connecting one transmitter/receiver pair to NUM_PORTS physical SDCKA/SDCKB port pairs. Provides per-line synchronisation and glitch filtering, registered output drive with per-port output enables, a bus-turnaround guard after transmission, loopback mode and drive-contention detection. It replaces the single-port fixed sync/tristate logic in the Maple Bus top level and sits between the transmitter/receiver cores and the pad tristate buffers.

---
 rtl/maple_phy_pkg.sv | 21 ++
 rtl/maple_line_filter.sv | 43 ++++
 rtl/maple_phy_mux.sv | 138 +++++++++++++
 tb/tb_maple_phy_mux.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/maple_phy_pkg.sv
// Shared types and default constants for the Maple Bus multi-port line interface.
package maple_phy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DRIVE      = 2'd1,
    ST_TURNAROUND = 2'd2
  } phy_state_t;

  localparam int DEF_NUM_PORTS         = 4;
  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_FILTER_CYCLES     = 2;
  localparam int DEF_TURNAROUND_CYCLES = 16;
  localparam int DEF_CONTENTION_CYCLES = 4;

  // Port-select width, kept at least one bit wide for single-port builds.
  function automatic int psel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maple_line_filter.sv
// One pad line: multi-flop synchroniser followed by a glitch filter that only
// follows the synchronised value once it has differed for FILTER_CYCLES cycles.
module maple_line_filter
  import maple_phy_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic din,
  output logic sync_out,
  output logic filt_out
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Idle Maple lines sit high, so everything restarts at 1.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sync_q   <= '1;
      filt_out <= 1'b1;
      cnt      <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (sync_out == filt_out) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filt_out <= sync_out;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/maple_phy_mux.sv
// Maple Bus line interface: routes one tx/rx core pair to NUM_PORTS pad pairs
// with filtering, turnaround blanking, loopback and drive-contention detection.
module maple_phy_mux
  import maple_phy_pkg::*;
#(
  parameter int NUM_PORTS         = DEF_NUM_PORTS,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES     = DEF_FILTER_CYCLES,
  parameter int TURNAROUND_CYCLES = DEF_TURNAROUND_CYCLES,
  parameter int CONTENTION_CYCLES = DEF_CONTENTION_CYCLES,
  localparam int PSEL_W           = psel_width(NUM_PORTS)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [PSEL_W-1:0]    port_sel,
  input  logic                 loopback,
  input  logic                 tx_a,
  input  logic                 tx_b,
  input  logic                 tx_active,
  output logic                 rx_a,
  output logic                 rx_b,
  output logic                 line_idle,
  output logic [PSEL_W-1:0]    act_port,
  output logic                 busy,
  output logic                 contention,
  input  logic                 clear_contention,
  input  logic [NUM_PORTS-1:0] sdcka_i,
  input  logic [NUM_PORTS-1:0] sdckb_i,
  output logic [NUM_PORTS-1:0] sdcka_o,
  output logic [NUM_PORTS-1:0] sdckb_o,
  output logic [NUM_PORTS-1:0] sdck_oe
);

  localparam int TW = $clog2(TURNAROUND_CYCLES + 1);
  localparam int OW = $clog2(SYNC_STAGES + 2);
  localparam int MW = $clog2(CONTENTION_CYCLES + 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURNAROUND_CYCLES);
  localparam logic [OW-1:0] OE_SETTLED = OW'(SYNC_STAGES + 1);
  localparam logic [MW-1:0] MIS_LIMIT  = MW'(CONTENTION_CYCLES);

  phy_state_t state, state_next;
  logic [PSEL_W-1:0]      port_next;
  logic [NUM_PORTS-1:0]   oe_next;
  logic [NUM_PORTS-1:0]   sync_a, sync_b, filt_a, filt_b;
  logic                   tx_a_q, tx_b_q;
  logic [SYNC_STAGES-1:0] dly_a, dly_b;
  logic [TW-1:0]          turn_cnt;
  logic [OW-1:0]          oe_cnt;
  logic [MW-1:0]          mis_cnt, mis_next;
  logic                   check_en, mismatch;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_line
    maple_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
      .aclk(aclk), .aresetn(aresetn), .din(sdcka_i[p]), .sync_out(sync_a[p]), .filt_out(filt_a[p])
    );
    maple_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
      .aclk(aclk), .aresetn(aresetn), .din(sdckb_i[p]), .sync_out(sync_b[p]), .filt_out(filt_b[p])
    );
  end

  always_comb begin
    port_next = act_port;
    if (state == ST_IDLE && int'(port_sel) < NUM_PORTS) port_next = port_sel;
    state_next = state;
    case (state)
      ST_IDLE:       if (tx_active) state_next = ST_DRIVE;
      ST_DRIVE:      if (!tx_active) state_next = ST_TURNAROUND;
      ST_TURNAROUND: begin
        if (tx_active)                  state_next = ST_DRIVE;
        else if (turn_cnt == TURN_LAST) state_next = ST_IDLE;
      end
      default:       state_next = ST_IDLE;
    endcase
    oe_next = '0;
    if (state_next == ST_DRIVE && !loopback) oe_next[port_next] = 1'b1;
  end

  // Readback of act_port is compared with what we drove SYNC_STAGES+1 edges ago,
  // which is the round trip through the output register and the synchroniser.
  always_comb begin
    check_en = (state == ST_DRIVE) && !loopback && (oe_cnt == OE_SETTLED);
    mismatch = (sync_a[act_port] != dly_a[SYNC_STAGES-1]) ||
               (sync_b[act_port] != dly_b[SYNC_STAGES-1]);
    mis_next = '0;
    if (check_en && mismatch) mis_next = (mis_cnt == MIS_LIMIT) ? mis_cnt : mis_cnt + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      act_port   <= '0;
      sdck_oe    <= '0;
      tx_a_q     <= 1'b1;
      tx_b_q     <= 1'b1;
      dly_a      <= '1;
      dly_b      <= '1;
      turn_cnt   <= '0;
      oe_cnt     <= '0;
      mis_cnt    <= '0;
      contention <= 1'b0;
    end else begin
      state    <= state_next;
      act_port <= port_next;
      sdck_oe  <= oe_next;
      tx_a_q   <= tx_a;
      tx_b_q   <= tx_b;
      dly_a    <= {dly_a[SYNC_STAGES-2:0], tx_a_q};
      dly_b    <= {dly_b[SYNC_STAGES-2:0], tx_b_q};
      turn_cnt <= (state == ST_TURNAROUND && state_next == ST_TURNAROUND) ? turn_cnt + 1'b1 : '0;
      if (state == ST_DRIVE && |sdck_oe)
        oe_cnt <= (oe_cnt == OE_SETTLED) ? oe_cnt : oe_cnt + 1'b1;
      else
        oe_cnt <= '0;
      mis_cnt <= mis_next;
      if (mis_next == MIS_LIMIT)  contention <= 1'b1;
      else if (clear_contention)  contention <= 1'b0;
    end
  end

  assign sdcka_o   = {NUM_PORTS{tx_a_q}};
  assign sdckb_o   = {NUM_PORTS{tx_b_q}};
  assign busy      = (state != ST_IDLE);
  assign line_idle = filt_a[act_port] & filt_b[act_port];

  always_comb begin
    if (loopback) begin
      rx_a = tx_a;
      rx_b = tx_b;
    end else if (busy) begin
      rx_a = 1'b1;
      rx_b = 1'b1;
    end else begin
      rx_a = filt_a[act_port];
      rx_b = filt_b[act_port];
    end
  end

endmodule

// File: tb/tb_maple_phy_mux.sv
// Bench for maple_phy_mux: directed scenarios with literal expectations, then
// random traffic compared every cycle against a history-based behavioural model.
module tb_maple_phy_mux;

  localparam int NP = 4;
  localparam int S  = 2;
  localparam int F  = 2;
  localparam int T  = 16;
  localparam int C  = 4;

  logic          aclk = 1'b0;
  logic          aresetn, loopback, tx_a, tx_b, tx_active, clear_contention;
  logic [1:0]    port_sel;
  logic [NP-1:0] sdcka_i, sdckb_i;
  logic          rx_a, rx_b, line_idle, busy, contention;
  logic [1:0]    act_port;
  logic [NP-1:0] sdcka_o, sdckb_o, sdck_oe;

  always #5 aclk = ~aclk;

  maple_phy_mux #(
    .NUM_PORTS(NP), .SYNC_STAGES(S), .FILTER_CYCLES(F),
    .TURNAROUND_CYCLES(T), .CONTENTION_CYCLES(C)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .port_sel(port_sel), .loopback(loopback),
    .tx_a(tx_a), .tx_b(tx_b), .tx_active(tx_active), .rx_a(rx_a), .rx_b(rx_b),
    .line_idle(line_idle), .act_port(act_port), .busy(busy), .contention(contention),
    .clear_contention(clear_contention), .sdcka_i(sdcka_i), .sdckb_i(sdckb_i),
    .sdcka_o(sdcka_o), .sdckb_o(sdckb_o), .sdck_oe(sdck_oe)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Model: pad and tx histories (bit 0 = sample at the latest edge) plus
  // a transmit/blank bookkeeping view of the bus owner.
  bit [S+F-1:0] ha [NP];
  bit [S+F-1:0] hb [NP];
  bit [S+1:0]   da = '1, db = '1;
  bit [NP-1:0]  m_fa = '1, m_fb = '1, m_oe = '0;
  bit           m_pa = 1'b1, m_pb = 1'b1, m_cont = 1'b0, m_driving = 1'b0;
  int           m_act = 0, m_blank = 0, m_age = 0, m_run = 0;
  bit           chk, mism, busy_e;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge aclk);
      #1;
    end
  endtask

  always @(posedge aclk) begin
    if (!aresetn) begin
      for (int p = 0; p < NP; p++) begin
        ha[p] = '1;
        hb[p] = '1;
      end
      da = '1; db = '1; m_fa = '1; m_fb = '1; m_oe = '0;
      m_pa = 1'b1; m_pb = 1'b1; m_cont = 1'b0; m_driving = 1'b0;
      m_act = 0; m_blank = 0; m_age = 0; m_run = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        ha[p] = {ha[p][S+F-2:0], sdcka_i[p]};
        hb[p] = {hb[p][S+F-2:0], sdckb_i[p]};
        if (ha[p][S +: F] == {F{~m_fa[p]}}) m_fa[p] = ~m_fa[p];
        if (hb[p][S +: F] == {F{~m_fb[p]}}) m_fb[p] = ~m_fb[p];
      end
      da = {da[S:0], tx_a};
      db = {db[S:0], tx_b};
      chk  = m_driving && !loopback && (m_age >= S + 1);
      mism = (ha[m_act][S] != da[S+1]) || (hb[m_act][S] != db[S+1]);
      if (chk && mism) m_run = (m_run < C) ? m_run + 1 : C;
      else             m_run = 0;
      if (m_run == C)             m_cont = 1'b1;
      else if (clear_contention)  m_cont = 1'b0;
      if (m_driving && m_oe != 0) m_age = (m_age < S + 1) ? m_age + 1 : m_age;
      else                        m_age = 0;
      if (m_driving) begin
        if (!tx_active) begin
          m_driving = 1'b0;
          m_blank   = T + 1;
        end
      end else if (m_blank > 0) begin
        if (tx_active) begin
          m_driving = 1'b1;
          m_blank   = 0;
        end else begin
          m_blank--;
        end
      end else begin
        if (int'(port_sel) < NP) m_act = int'(port_sel);
        if (tx_active) m_driving = 1'b1;
      end
      m_oe = '0;
      if (m_driving && !loopback) m_oe[m_act] = 1'b1;
      m_pa = tx_a;
      m_pb = tx_b;
    end
  end

  always @(negedge aclk) begin
    if (cmp_on) begin
      busy_e = m_driving || (m_blank > 0);
      checkOutput("oe",        sdck_oe, m_oe);
      checkOutput("sdcka_o",   sdcka_o, {NP{m_pa}});
      checkOutput("sdckb_o",   sdckb_o, {NP{m_pb}});
      checkOutput("act_port",  act_port, m_act);
      checkOutput("busy",      busy, busy_e);
      checkOutput("contention", contention, m_cont);
      checkOutput("line_idle", line_idle, m_fa[m_act] & m_fb[m_act]);
      checkOutput("rx_a", rx_a, loopback ? tx_a : (busy_e ? 1'b1 : m_fa[m_act]));
      checkOutput("rx_b", rx_b, loopback ? tx_b : (busy_e ? 1'b1 : m_fb[m_act]));
    end
  end

  initial begin
    int j;
    aresetn = 1'b0; port_sel = 2'd0; loopback = 1'b0; tx_a = 1'b1; tx_b = 1'b1;
    tx_active = 1'b0; clear_contention = 1'b0; sdcka_i = '1; sdckb_i = '1;
    applyStimulus(1);
    cmp_on = 1'b1;
    applyStimulus(2);
    checkOutput("rst_oe", sdck_oe, 4'b0000);
    checkOutput("rst_pad_a", sdcka_o, 4'b1111);
    checkOutput("rst_rx_a", rx_a, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_line_idle", line_idle, 1'b1);
    checkOutput("rst_contention", contention, 1'b0);
    checkOutput("rst_act_port", act_port, 2'd0);

    // Port selection and glitch filtering on port 2.
    aresetn = 1'b1; port_sel = 2'd2;
    applyStimulus(1);
    checkOutput("sel_act_port", act_port, 2'd2);
    sdcka_i[2] = 1'b0; applyStimulus(1); sdcka_i[2] = 1'b1; applyStimulus(6);
    checkOutput("glitch_rx_a", rx_a, 1'b1);
    sdcka_i = 4'b0100; applyStimulus(6);
    checkOutput("other_ports_rx_a", rx_a, 1'b1);
    checkOutput("other_ports_idle", line_idle, 1'b1);
    sdcka_i = 4'b0000; applyStimulus(3);
    checkOutput("hold_early_rx_a", rx_a, 1'b1);
    applyStimulus(1);
    checkOutput("hold_rx_a", rx_a, 1'b0);
    checkOutput("hold_line_idle", line_idle, 1'b0);
    applyStimulus(1); sdcka_i = '1; applyStimulus(5);
    checkOutput("release_rx_a", rx_a, 1'b1);

    // Transmission, port change during drive, turnaround blanking.
    tx_a = 1'b1; tx_active = 1'b1; applyStimulus(1);
    checkOutput("drv_oe", sdck_oe, 4'b0100);
    checkOutput("drv_busy", busy, 1'b1);
    tx_a = 1'b0; applyStimulus(1);
    checkOutput("drv_pad_0", sdcka_o[2], 1'b0);
    tx_a = 1'b1; applyStimulus(1);
    checkOutput("drv_pad_1", sdcka_o[2], 1'b1);
    port_sel = 2'd1; applyStimulus(2);
    checkOutput("drv_act_hold", act_port, 2'd2);
    tx_active = 1'b0; applyStimulus(1);
    checkOutput("turn_oe", sdck_oe, 4'b0000);
    applyStimulus(16);
    checkOutput("turn_busy", busy, 1'b1);
    checkOutput("turn_rx_a", rx_a, 1'b1);
    applyStimulus(1);
    checkOutput("turn_done_busy", busy, 1'b0);
    checkOutput("turn_done_act", act_port, 2'd2);
    applyStimulus(1);
    checkOutput("idle_act_update", act_port, 2'd1);

    // Loopback never drives the pads and echoes tx combinationally.
    port_sel = 2'd2; applyStimulus(1);
    loopback = 1'b1; tx_active = 1'b1; applyStimulus(1);
    checkOutput("lb_oe", sdck_oe, 4'b0000);
    tx_a = 1'b0; #1;
    checkOutput("lb_rx_a0", rx_a, 1'b0);
    tx_a = 1'b1; #1;
    checkOutput("lb_rx_a1", rx_a, 1'b1);
    applyStimulus(3);
    checkOutput("lb_oe_hold", sdck_oe, 4'b0000);
    tx_active = 1'b0; loopback = 1'b0; applyStimulus(20);
    checkOutput("lb_done_busy", busy, 1'b0);

    // Contention: port 2 held low while we drive high.
    sdcka_i[2] = 1'b0; tx_a = 1'b1; tx_b = 1'b1; tx_active = 1'b1;
    applyStimulus(7);
    checkOutput("cont_early", contention, 1'b0);
    applyStimulus(1);
    checkOutput("cont_set", contention, 1'b1);
    checkOutput("cont_still_driving", sdck_oe, 4'b0100);
    clear_contention = 1'b1; applyStimulus(1); clear_contention = 1'b0;
    checkOutput("cont_clear_blocked", contention, 1'b1);
    sdcka_i[2] = 1'b1; applyStimulus(5);
    clear_contention = 1'b1; applyStimulus(1); clear_contention = 1'b0;
    checkOutput("cont_cleared", contention, 1'b0);

    // Reset while driving.
    aresetn = 1'b0; applyStimulus(1);
    checkOutput("rst_drv_oe", sdck_oe, 4'b0000);
    checkOutput("rst_drv_busy", busy, 1'b0);
    aresetn = 1'b1; tx_active = 1'b0; port_sel = 2'd3; applyStimulus(2);
    checkOutput("post_rst_act", act_port, 2'd3);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) tx_active = ~tx_active;
      tx_a = ($urandom_range(0, 3) != 0);
      tx_b = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) port_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) loopback = ~loopback;
      if ($urandom_range(0, 5) == 0) begin
        j = $urandom_range(0, NP - 1);
        sdcka_i[j] = ~sdcka_i[j];
      end
      if ($urandom_range(0, 5) == 0) begin
        j = $urandom_range(0, NP - 1);
        sdckb_i[j] = ~sdckb_i[j];
      end
      clear_contention = ($urandom_range(0, 29) == 0);
      aresetn = ($urandom_range(0, 399) != 0);
      applyStimulus(1);
    end
    aresetn = 1'b1;
    applyStimulus(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
